muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer_pkg.sv | 22 ++
 rtl/muldiv_carry.sv | 14 +
 rtl/muldiv_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the iterative unsigned multiply/divide sequencer.
// The MULDIV_DIV_EN macro (used by the top level) enables the DIVU datapath.
package muldiv_sequencer_pkg;

    localparam logic [3:0]  ALU_ADD    = 4'b0010;
    localparam logic [3:0]  ALU_SUB    = 4'b0110;
    localparam int unsigned ITER_COUNT = 32;
    localparam int unsigned CNT_W      = $clog2(ITER_COUNT);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    typedef enum logic {
        OP_MULTU = 1'b0,
        OP_DIVU  = 1'b1
    } op_t;

endpackage

// File: rtl/muldiv_carry.sv
// Carry-out of an ADD or borrow-out of a SUB, recovered from the operand and
// result MSBs of the shared 32-bit ALU.
module muldiv_carry (
    input  logic a31,
    input  logic b31,
    input  logic r31,
    input  logic sub,
    output logic cout
);

    assign cout = sub ? ((~a31 & b31) | ((~a31 | b31) & r31))
                      : ((a31 & b31) | ((a31 | b31) & ~r31));

endmodule

// File: rtl/muldiv_sequencer.sv
// 32x32 unsigned shift-add multiplier / restoring divider time-sharing an external ALU.
// Define MULDIV_DIV_EN to build the DIVU path; otherwise every start performs MULTU.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result
);

    state_t           state_r, state_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;
    logic [31:0]      hi_r, lo_r, opnd_r;
    logic [31:0]      hi_nx_s, lo_nx_s, opnd_nx_s;
    logic             busy_r, busy_nx_s, done_r, done_nx_s;
    logic [31:0]      alu_in1_r, alu_in2_r, alu_in1_nx_s, alu_in2_nx_s;
    logic [3:0]       alu_ctrl_r, alu_ctrl_nx_s;
    logic             sub_s, cy_s;
`ifdef MULDIV_DIV_EN
    op_t              op_r, op_nx_s;
`else
    logic             unused_op_s;
    assign unused_op_s = op;
`endif

    assign sub_s = (alu_ctrl_r == ALU_SUB);

    muldiv_carry u_carry (
        .a31  (alu_in1_r[31]),
        .b31  (alu_in2_r[31]),
        .r31  (alu_result[31]),
        .sub  (sub_s),
        .cout (cy_s)
    );

    // Next-state, datapath step and next ALU operands (ALU ports are registered copies)
    always_comb begin
        state_nx_s    = state_r;
        cnt_nx_s      = cnt_r;
        hi_nx_s       = hi_r;
        lo_nx_s       = lo_r;
        opnd_nx_s     = opnd_r;
        busy_nx_s     = busy_r;
        done_nx_s     = 1'b0;
        alu_in1_nx_s  = 32'd0;
        alu_in2_nx_s  = 32'd0;
        alu_ctrl_nx_s = ALU_ADD;
`ifdef MULDIV_DIV_EN
        op_nx_s       = op_r;
`endif
        case (state_r)
            IDLE: begin
                busy_nx_s = 1'b0;
                if (start) begin
                    busy_nx_s  = 1'b1;
                    cnt_nx_s   = '0;
                    hi_nx_s    = 32'd0;
                    state_nx_s = RUN;
`ifdef MULDIV_DIV_EN
                    op_nx_s = op_t'(op);
                    if (op_t'(op) == OP_DIVU) begin
                        lo_nx_s   = opa;
                        opnd_nx_s = opb;
                        // Divide by zero bypasses the iterations entirely
                        if (opb == 32'd0) begin
                            hi_nx_s    = opa;
                            lo_nx_s    = 32'hFFFF_FFFF;
                            state_nx_s = FIN;
                        end else begin
                            state_nx_s = RUN;
                        end
                    end else begin
                        lo_nx_s   = opb;
                        opnd_nx_s = opa;
                    end
`else
                    lo_nx_s   = opb;
                    opnd_nx_s = opa;
`endif
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                cnt_nx_s = cnt_r + 1'b1;
                if (cnt_r == LAST_ITER) begin
                    state_nx_s = FIN;
                end else begin
                    state_nx_s = RUN;
                end
`ifdef MULDIV_DIV_EN
                if (op_r == OP_DIVU) begin
                    // hi_r[31] is the bit shifted out of the 33-bit partial remainder
                    if (hi_r[31] | ~cy_s) begin
                        hi_nx_s = alu_result;
                        lo_nx_s = {lo_r[30:0], 1'b1};
                    end else begin
                        hi_nx_s = {hi_r[30:0], lo_r[31]};
                        lo_nx_s = {lo_r[30:0], 1'b0};
                    end
                end else if (lo_r[0]) begin
                    hi_nx_s = {cy_s, alu_result[31:1]};
                    lo_nx_s = {alu_result[0], lo_r[31:1]};
                end else begin
                    hi_nx_s = {1'b0, hi_r[31:1]};
                    lo_nx_s = {hi_r[0], lo_r[31:1]};
                end
`else
                if (lo_r[0]) begin
                    hi_nx_s = {cy_s, alu_result[31:1]};
                    lo_nx_s = {alu_result[0], lo_r[31:1]};
                end else begin
                    hi_nx_s = {1'b0, hi_r[31:1]};
                    lo_nx_s = {hi_r[0], lo_r[31:1]};
                end
`endif
            end
            FIN: begin
                state_nx_s = IDLE;
                cnt_nx_s   = '0;
                done_nx_s  = 1'b1;
            end
            default: begin
                state_nx_s = IDLE;
                busy_nx_s  = 1'b0;
            end
        endcase

        if (state_nx_s == RUN) begin
`ifdef MULDIV_DIV_EN
            if (op_nx_s == OP_DIVU) begin
                alu_in1_nx_s  = {hi_nx_s[30:0], lo_nx_s[31]};
                alu_in2_nx_s  = opnd_nx_s;
                alu_ctrl_nx_s = ALU_SUB;
            end else begin
                alu_in1_nx_s  = hi_nx_s;
                alu_in2_nx_s  = opnd_nx_s;
                alu_ctrl_nx_s = ALU_ADD;
            end
`else
            alu_in1_nx_s  = hi_nx_s;
            alu_in2_nx_s  = opnd_nx_s;
            alu_ctrl_nx_s = ALU_ADD;
`endif
        end else begin
            alu_in1_nx_s  = 32'd0;
            alu_in2_nx_s  = 32'd0;
            alu_ctrl_nx_s = ALU_ADD;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
            opnd_r     <= 32'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            alu_in1_r  <= 32'd0;
            alu_in2_r  <= 32'd0;
            alu_ctrl_r <= ALU_ADD;
`ifdef MULDIV_DIV_EN
            op_r       <= OP_MULTU;
`endif
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            hi_r       <= hi_nx_s;
            lo_r       <= lo_nx_s;
            opnd_r     <= opnd_nx_s;
            busy_r     <= busy_nx_s;
            done_r     <= done_nx_s;
            alu_in1_r  <= alu_in1_nx_s;
            alu_in2_r  <= alu_in2_nx_s;
            alu_ctrl_r <= alu_ctrl_nx_s;
`ifdef MULDIV_DIV_EN
            op_r       <= op_nx_s;
`endif
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign hi       = hi_r;
    assign lo       = lo_r;
    assign alu_in1  = alu_in1_r;
    assign alu_in2  = alu_in2_r;
    assign alu_ctrl = alu_ctrl_r;

endmodule
